round_robin_grant_arbiter: RTL

ROUND_ROBIN_GRANT_ARBITER -- requirements
Module: round_robin_grant_arbiter

---
 rtl/round_robin_grant_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/round_robin_grant_arbiter.sv
// Eight-requester round-robin arbiter with a bounded hold time and a
// one-cycle break-before-make gap between consecutive grants.
module round_robin_grant_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic [7:0] Request_In,
  input  logic       Release_In,
  output logic       Grant_Valid_Out,
  output logic [2:0] Grant_Index_Out,
  output logic [7:0] Grant_Onehot_Out,
  output logic       Timeout_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] onehot_q, onehot_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick_s;
  logic       released_s;
  logic       expired_s;

  // First set request at or above ptr, wrapping 7->0; smallest offset wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] cand;
    rr_pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        rr_pick = cand;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  assign pick_s     = rr_pick(Request_In, ptr_q);
  assign released_s = Release_In | ~Request_In[idx_q];
  assign expired_s  = (hold_q == HOLD_LAST);

  // Next-state, pointer, hold counter and registered output values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (Request_In != 8'h00) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = pick_s;
          onehot_d = 8'h01 << pick_s;
          hold_d   = 8'h00;
        end else begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          onehot_d = 8'h00;
        end
      end
      GRANT: begin
        if (released_s || expired_s) begin
          state_d   = GAP;
          valid_d   = 1'b0;
          onehot_d  = 8'h00;
          ptr_d     = idx_q + 3'd1;
          // A release on the final cycle takes precedence over the timeout.
          timeout_d = expired_s & ~released_s;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = 8'h00;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock edge.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= 8'h00;
      valid_q   <= 1'b0;
      idx_q     <= 3'd0;
      onehot_q  <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      timeout_q <= timeout_d;
    end
  end

  assign Grant_Valid_Out  = valid_q;
  assign Grant_Index_Out  = idx_q;
  assign Grant_Onehot_Out = onehot_q;
  assign Timeout_Out      = timeout_q;

endmodule
